// File: rtl/dot8_lane_sequencer.sv
// Time-multiplexes a NUM_LANES-wide dot8 request over NUM_PES enable-gated PEs
// and reassembles the returning results into one tagged commit beat.
module dot8_lane_sequencer #(
  parameter int unsigned NUM_LANES      = 4,
  parameter int unsigned NUM_PES        = 2,
  parameter int unsigned LATENCY        = 2,
  parameter int unsigned DATA_IN_WIDTH  = 64,
  parameter int unsigned DATA_OUT_WIDTH = 32,
  parameter int unsigned TAG_WIDTH      = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                valid_in,
  input  logic [NUM_LANES*DATA_IN_WIDTH-1:0]  data_in,
  input  logic [TAG_WIDTH-1:0]                tag_in,
  output logic                                ready_in,
  output logic                                pe_enable,
  output logic [NUM_PES*DATA_IN_WIDTH-1:0]    pe_data_out,
  input  logic [NUM_PES*DATA_OUT_WIDTH-1:0]   pe_data_in,
  output logic                                valid_out,
  output logic [NUM_LANES*DATA_OUT_WIDTH-1:0] data_out,
  output logic [TAG_WIDTH-1:0]                tag_out,
  input  logic                                ready_out
);

  localparam int unsigned BATCHES = NUM_LANES / NUM_PES;
  localparam int unsigned BCNT_W  = (BATCHES > 1) ? $clog2(BATCHES) : 1;
  localparam int unsigned LAST    = LATENCY - 1;

  typedef struct packed {
    logic                 v;
    logic [BCNT_W-1:0]    idx;
    logic [TAG_WIDTH-1:0] tag;
  } trk_t;

  logic                                stall;
  logic                                last_batch;
  logic                                last_landing;
  logic [BCNT_W-1:0]                   bcnt_q, bcnt_d;
  trk_t                                trk_q [LATENCY];
  trk_t                                trk_d [LATENCY];
  logic                                valid_out_q, valid_out_d;
  logic [NUM_LANES*DATA_OUT_WIDTH-1:0] data_out_q, data_out_d;
  logic [TAG_WIDTH-1:0]                tag_out_q, tag_out_d;

  assign stall        = valid_out_q & ~ready_out;
  assign pe_enable    = ~stall;
  assign last_batch   = (bcnt_q == BCNT_W'(BATCHES - 1));
  assign ready_in     = valid_in & pe_enable & last_batch;
  assign last_landing = pe_enable & trk_q[LAST].v &
                        (trk_q[LAST].idx == BCNT_W'(BATCHES - 1));

  assign valid_out = valid_out_q;
  assign data_out  = data_out_q;
  assign tag_out   = tag_out_q;

  // Issue counter: advances on every accepted batch, tied to zero for a single batch
  always_comb begin
    bcnt_d = bcnt_q;
    if ((BATCHES > 1) && valid_in && pe_enable) begin
      if (last_batch) begin
        bcnt_d = '0;
      end else begin
        bcnt_d = bcnt_q + BCNT_W'(1);
      end
    end
  end

  // Operand mux: the current batch's lanes go to the PEs
  always_comb begin
    pe_data_out = '0;
    for (int unsigned b = 0; b < BATCHES; b++) begin
      if (bcnt_q == BCNT_W'(b)) begin
        for (int unsigned p = 0; p < NUM_PES; p++) begin
          pe_data_out[p*DATA_IN_WIDTH +: DATA_IN_WIDTH] =
            data_in[(b*NUM_PES + p)*DATA_IN_WIDTH +: DATA_IN_WIDTH];
        end
      end
    end
  end

  // Tracking pipe mirrors the PE pipeline, so it only moves when the PEs do
  always_comb begin
    trk_d = trk_q;
    if (pe_enable) begin
      trk_d[0].v   = valid_in;
      trk_d[0].idx = bcnt_q;
      trk_d[0].tag = tag_in;
      for (int unsigned s = 1; s < LATENCY; s++) begin
        trk_d[s] = trk_q[s-1];
      end
    end
  end

  // Result reassembly; a stalled beat keeps its slots untouched
  always_comb begin
    data_out_d  = data_out_q;
    tag_out_d   = tag_out_q;
    valid_out_d = last_landing | stall;
    if (pe_enable && trk_q[LAST].v) begin
      for (int unsigned b = 0; b < BATCHES; b++) begin
        if (trk_q[LAST].idx == BCNT_W'(b)) begin
          for (int unsigned p = 0; p < NUM_PES; p++) begin
            data_out_d[(b*NUM_PES + p)*DATA_OUT_WIDTH +: DATA_OUT_WIDTH] =
              pe_data_in[p*DATA_OUT_WIDTH +: DATA_OUT_WIDTH];
          end
        end
      end
      if (last_landing) begin
        tag_out_d = trk_q[LAST].tag;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcnt_q      <= '0;
      valid_out_q <= 1'b0;
      data_out_q  <= '0;
      tag_out_q   <= '0;
      for (int unsigned s = 0; s < LATENCY; s++) begin
        trk_q[s] <= '0;
      end
    end else begin
      bcnt_q      <= bcnt_d;
      valid_out_q <= valid_out_d;
      data_out_q  <= data_out_d;
      tag_out_q   <= tag_out_d;
      trk_q       <= trk_d;
    end
  end

endmodule

// File: doc/dot8_lane_sequencer.md
# dot8_lane_sequencer

Time-multiplexing sequencer between the dot8 execute port and its packed-byte dot-product PEs. It accepts one NUM_LANES-wide request and issues it to NUM_PES processing elements over NUM_LANES/NUM_PES consecutive enabled cycles. It tracks the batches through the PEs' fixed enable-gated pipeline and reassembles the returning results into one NUM_LANES-wide commit beat. The tag travels alongside the data unchanged.

## Interface
- NUM_LANES, 4, lanes per request
- NUM_PES, 2, PE count; NUM_LANES % NUM_PES == 0 and 1 <= NUM_PES <= NUM_LANES
- LATENCY, 2, PE pipeline depth in enabled cycles; must be >= 1
- DATA_IN_WIDTH, 64, per-lane operand width ({rs2, rs1})
- DATA_OUT_WIDTH, 32, per-lane result width
- TAG_WIDTH, 8, opaque tag width
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- valid_in  in  1  request valid
- data_in  in  NUM_LANES*DATA_IN_WIDTH  lane operands; lane i at [i*DATA_IN_WIDTH +: DATA_IN_WIDTH]
- tag_in  in  TAG_WIDTH  request tag
- ready_in  out  1  request consumed this cycle
- pe_enable  out  1  advance strobe for the PE pipelines
- pe_data_out  out  NUM_PES*DATA_IN_WIDTH  operands to PEs
- pe_data_in  in  NUM_PES*DATA_OUT_WIDTH  PE results, LATENCY enabled cycles after issue
- valid_out  out  1  result beat valid
- data_out  out  NUM_LANES*DATA_OUT_WIDTH  reassembled lane results
- tag_out  out  TAG_WIDTH  tag of the result beat
- ready_out  in  1  downstream accepts

## Operation
- BATCHES = NUM_LANES/NUM_PES. BCNT_W = max(1, clog2(BATCHES)).
- stall = valid_out & ~ready_out. pe_enable = ~stall (combinational).
- Issue counter bcnt:
  - Increments on valid_in & pe_enable.
  - Wraps from BATCHES-1 to 0.
  - Holds otherwise.
- pe_data_out[p] = data_in lane (bcnt*NUM_PES + p). This is a pure mux and is valid whenever valid_in is high.
- ready_in = valid_in & pe_enable & (bcnt == BATCHES-1). A request is retired only on its last batch. Upstream holds valid_in, data_in and tag_in stable until ready_in.
- Tracking pipe:
  - LATENCY stages, each holding {v, batch index, tag}.
  - Stage 0 loads {valid_in, bcnt, tag_in}.
  - The pipe shifts only when pe_enable = 1, so it stays aligned with the PEs.
- Landing: when pe_enable = 1 and the last stage has v = 1, pe_data_in[p] is written into result slot lane (idx*NUM_PES + p).
- Last batch landing (idx == BATCHES-1):
  - tag_out is loaded from the stage tag.
  - valid_out is set at the next edge.
- valid_out_next = last_landing | stall.
  - An accepted beat with no new completion clears valid_out.
  - A beat accepted in the same cycle as a completion is replaced seamlessly.
- No slot is written while stalled, so data_out and tag_out are stable while valid_out & ~ready_out.
- valid_in dropping mid-sequence: bcnt holds; a bubble enters the tracking pipe; the sequence resumes on the next valid cycle.
- BATCHES == 1: bcnt is tied to 0; ready_in = valid_in & pe_enable.

## Timing
- Reset values, applied asynchronously:
  - bcnt = 0, all tracking v = 0, valid_out = 0, data_out = 0, tag_out = 0.
  - Combinational outputs then follow: pe_enable = 1, ready_in = valid_in when BATCHES = 1, otherwise 0.
- Reset mid-operation discards all in-flight batches and any pending beat. Nothing is emitted afterwards for them.
- Latency with no stalls: first batch accepted at cycle t gives valid_out high at cycle t + BATCHES + LATENCY - 1 after the edge.
  - Example: cycle 0 issue, NUM_LANES = 4, NUM_PES = 2, LATENCY = 2 gives valid_out at cycle 3.
- Throughput: one request per BATCHES cycles when ready_out is held at 1.
- Back-to-back requests need no bubble; bcnt wraps in the same cycle ready_in fires.
- During a stall:
  - pe_enable = 0, ready_in = 0, bcnt frozen, tracking pipe frozen.
  - PEs hold their state because they are gated by pe_enable.
- Release: the cycle ready_out goes high, pe_enable is 1 again and landing resumes in that same cycle.

## Test plan
- Single request, defaults, lane operands a = 0x01020304 and b = 0x01010101 in every lane, PE model computing the unsigned byte dot product.
  - ready_in pulses on cycle 1 only.
  - valid_out at cycle 3.
  - data_out = 4 × 0x0000000A.
  - tag_out = tag_in.
- Four back-to-back requests with tags 1, 2, 3, 4 and ready_out = 1.
  - valid_out beats 2 cycles apart.
  - Tags appear in order 1, 2, 3, 4.
  - No lane mixing between requests (each lane carries a distinct value).
- Hold ready_out = 0 for 5 cycles while a beat is valid with a second request in flight.
  - pe_enable = 0 throughout.
  - data_out and tag_out stable.
  - On release, the first beat is accepted and the second appears with no corruption.
- valid_in low for 2 cycles between batch 0 and batch 1.
  - bcnt holds at 1.
  - Result is still correct, with valid_out delayed by 2 cycles.
- Assert reset with one request mid-flight (bcnt = 1, one batch inside the PEs).
  - All outputs return to their reset values immediately.
  - No valid_out occurs for that request.
  - A fresh request afterwards completes normally.
- Parameterisation NUM_PES = NUM_LANES = 4, LATENCY = 1.
  - ready_in = valid_in.
  - valid_out appears 1 cycle after issue.
  - Back-to-back valid_out every cycle.
